// File: rtl/cfs_algn_pkg.sv
// Shared types and helpers for the aligner configuration path.
//   cfs_algn_err_t        : one-cycle error code reported with a rejected/aborted request
//   cfs_algn_cfg_state_t  : configuration sequencer state
//   algn_cfg_legal()      : offset/size legality rule for a DATA_BYTES-wide datapath
package cfs_algn_pkg;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_TIMEOUT = 2'd2
    } cfs_algn_err_t;

    typedef enum logic {
        CFG_IDLE  = 1'b0,
        CFG_DRAIN = 1'b1
    } cfs_algn_cfg_state_t;

    // A window is legal when it is non-empty, fits in the word, and the
    // word boundary plus offset is a whole number of chunks of 'size' bytes.
    function automatic logic algn_cfg_legal(input int unsigned offset,
                                            input int unsigned size,
                                            input int unsigned data_bytes);
        logic legal;
        legal = 1'b0;
        if ((size != 0) && (size <= data_bytes) && (offset + size <= data_bytes))
            legal = (((data_bytes + offset) % size) == 0);
        return legal;
    endfunction

endpackage

// File: rtl/cfs_algn_inflight_cnt.sv
// Saturating count of bytes popped into cfs_ctrl but not yet pushed out.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   pop_hs, pop_size    : pop handshake and its byte count (added)
//   push_hs, push_size  : push handshake and its byte count (subtracted)
//   count               : registered in-flight byte count
module cfs_algn_inflight_cnt #(
    parameter int CNT_WIDTH  = 4,
    parameter int SIZE_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pop_hs,
    input  logic [SIZE_WIDTH-1:0] pop_size,
    input  logic                  push_hs,
    input  logic [SIZE_WIDTH-1:0] push_size,
    output logic [CNT_WIDTH-1:0]  count
);

    localparam int SUM_W = CNT_WIDTH + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {1'b0, {CNT_WIDTH{1'b1}}};

    logic [SUM_W-1:0] add_term;
    logic [SUM_W-1:0] sub_term;
    logic [SUM_W-1:0] sum;

    // Clamp to [0, CNT_MAX]; either clamp means the neighbours broke protocol.
    function automatic logic [CNT_WIDTH-1:0] sat_update(input logic [SUM_W-1:0] base,
                                                        input logic [SUM_W-1:0] sub);
        logic [SUM_W-1:0] diff;
        logic [CNT_WIDTH-1:0] res;
        diff = base - sub;
        if (sub > base)
            res = '0;
        else if (diff > CNT_MAX)
            res = '1;
        else
            res = diff[CNT_WIDTH-1:0];
        return res;
    endfunction

    assign add_term = pop_hs  ? SUM_W'(pop_size)  : '0;
    assign sub_term = push_hs ? SUM_W'(push_size) : '0;
    assign sum      = {1'b0, count} + add_term;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else
            count <= sat_update(sum, sub_term);
    end

`ifndef SYNTHESIS
    a_no_underflow: assert property (@(posedge clk) disable iff (reset) sub_term <= sum);
    a_no_overflow:  assert property (@(posedge clk) disable iff (reset)
                                     (sub_term > sum) || ((sum - sub_term) <= CNT_MAX));
`endif

endmodule

// File: rtl/cfs_algn_cfg_sched.sv
// Configuration sequencer for cfs_ctrl: accepts offset/size requests,
// rejects illegal ones, blocks pops while already-popped bytes drain out,
// then applies the new ctrl_offset/ctrl_size (or aborts on drain timeout).
// Ports:
//   clk, reset                                  : clock, asynchronous active-high reset
//   cfg_valid/cfg_offset/cfg_size/cfg_ready     : request handshake
//   cfg_done, cfg_err                           : one-cycle completion / error code
//   ctrl_offset, ctrl_size                      : live configuration to cfs_ctrl
//   up_pop_valid/up_pop_ready                   : RX FIFO pop port
//   dp_pop_valid/dp_pop_ready/dp_pop_size       : cfs_ctrl pop port
//   dp_push_valid/dp_push_ready/dp_push_size    : cfs_ctrl push port monitor
//   inflight, busy                              : byte count in cfs_ctrl, sequencer not idle
module cfs_algn_cfg_sched
    import cfs_algn_pkg::*;
#(
    parameter int ALGN_DATA_WIDTH = 32,
    parameter int DRAIN_TIMEOUT   = 256,
    localparam int DATA_BYTES        = ALGN_DATA_WIDTH / 8,
    localparam int ALGN_OFFSET_WIDTH = (DATA_BYTES < 2) ? 1 : $clog2(DATA_BYTES),
    localparam int ALGN_SIZE_WIDTH   = $clog2(DATA_BYTES) + 1,
    localparam int CNT_WIDTH         = $clog2(2 * DATA_BYTES) + 1,
    localparam int TMO_WIDTH         = $clog2(DRAIN_TIMEOUT)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_valid,
    input  logic [ALGN_OFFSET_WIDTH-1:0] cfg_offset,
    input  logic [ALGN_SIZE_WIDTH-1:0]   cfg_size,
    output logic                         cfg_ready,
    output logic                         cfg_done,
    output logic [1:0]                   cfg_err,
    output logic [ALGN_OFFSET_WIDTH-1:0] ctrl_offset,
    output logic [ALGN_SIZE_WIDTH-1:0]   ctrl_size,
    input  logic                         up_pop_valid,
    output logic                         up_pop_ready,
    output logic                         dp_pop_valid,
    input  logic                         dp_pop_ready,
    input  logic [ALGN_SIZE_WIDTH-1:0]   dp_pop_size,
    input  logic                         dp_push_valid,
    input  logic                         dp_push_ready,
    input  logic [ALGN_SIZE_WIDTH-1:0]   dp_push_size,
    output logic [CNT_WIDTH-1:0]         inflight,
    output logic                         busy
);

    localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(DRAIN_TIMEOUT - 1);

    cfs_algn_cfg_state_t state, state_nxt;
    cfs_algn_err_t       err_q, err_nxt;

    logic                         hold;
    logic                         pop_hs;
    logic                         push_hs;
    logic                         cfg_legal;
    logic                         done_nxt;
    logic                         pend_load;
    logic [TMO_WIDTH-1:0]         tmo_cnt, tmo_nxt;
    logic [ALGN_OFFSET_WIDTH-1:0] pend_offset, ctrl_offset_nxt;
    logic [ALGN_SIZE_WIDTH-1:0]   pend_size, ctrl_size_nxt;

    // Pops are gated purely combinationally so reset drops the gate at once.
    assign hold         = (state == CFG_DRAIN);
    assign dp_pop_valid = up_pop_valid & ~hold;
    assign up_pop_ready = dp_pop_ready & ~hold;
    assign pop_hs       = dp_pop_valid & dp_pop_ready;
    assign push_hs      = dp_push_valid & dp_push_ready;

    assign cfg_ready = (state == CFG_IDLE);
    assign busy      = (state != CFG_IDLE);
    assign cfg_err   = err_q;
    assign cfg_legal = algn_cfg_legal(32'(cfg_offset), 32'(cfg_size), DATA_BYTES);

    cfs_algn_inflight_cnt #(
        .CNT_WIDTH (CNT_WIDTH),
        .SIZE_WIDTH(ALGN_SIZE_WIDTH)
    ) u_inflight_cnt (
        .clk      (clk),
        .reset    (reset),
        .pop_hs   (pop_hs),
        .pop_size (dp_pop_size),
        .push_hs  (push_hs),
        .push_size(dp_push_size),
        .count    (inflight)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= CFG_IDLE;
        else
            state <= state_nxt;
    end

    // The drain test uses the registered count, so a push in this cycle
    // only lets the apply happen one cycle later.
    always_comb begin
        state_nxt       = state;
        err_nxt         = ERR_NONE;
        done_nxt        = 1'b0;
        pend_load       = 1'b0;
        tmo_nxt         = tmo_cnt;
        ctrl_offset_nxt = ctrl_offset;
        ctrl_size_nxt   = ctrl_size;
        case (state)
            CFG_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_legal) begin
                        pend_load = 1'b1;
                        tmo_nxt   = '0;
                        state_nxt = CFG_DRAIN;
                    end else begin
                        err_nxt = ERR_ILLEGAL;
                    end
                end
            end
            CFG_DRAIN: begin
                if (inflight == '0) begin
                    ctrl_offset_nxt = pend_offset;
                    ctrl_size_nxt   = pend_size;
                    done_nxt        = 1'b1;
                    state_nxt       = CFG_IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    // Residual partial bytes stay in cfs_ctrl; old config is kept.
                    err_nxt   = ERR_TIMEOUT;
                    state_nxt = CFG_IDLE;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
            default: state_nxt = CFG_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_offset <= '0;
            ctrl_size   <= ALGN_SIZE_WIDTH'(1);
            cfg_done    <= 1'b0;
            err_q       <= ERR_NONE;
            tmo_cnt     <= '0;
        end else begin
            ctrl_offset <= ctrl_offset_nxt;
            ctrl_size   <= ctrl_size_nxt;
            cfg_done    <= done_nxt;
            err_q       <= err_nxt;
            tmo_cnt     <= tmo_nxt;
        end
    end

    // Pending request is pure data: only meaningful while in DRAIN.
    always_ff @(posedge clk) begin
        if (pend_load) begin
            pend_offset <= cfg_offset;
            pend_size   <= cfg_size;
        end
    end

endmodule

// File: doc/cfs_algn_cfg_sched.md
# cfs_algn_cfg_sched

Configuration sequencer for the aligner datapath controller `cfs_ctrl`. It accepts offset/size reconfiguration requests and checks them for legality. Before applying a new `ctrl_offset`/`ctrl_size`, it gates the pop handshake into `cfs_ctrl` and waits until every byte already popped has been pushed out. It sits between the RX FIFO pop port and `cfs_ctrl`, and drives the controller's `ctrl_*` inputs.

## Interface
- `ALGN_DATA_WIDTH`, 32, datapath width in bits (multiple of 8); `DATA_BYTES = ALGN_DATA_WIDTH/8`.
- `DRAIN_TIMEOUT`, 256, maximum cycles spent in DRAIN (≥ 2).
- Derived localparams:
  - `ALGN_OFFSET_WIDTH`, `ALGN_SIZE_WIDTH`: same formulas as `cfs_ctrl`.
  - `CNT_WIDTH = $clog2(2*DATA_BYTES)+1`.
  - `TMO_WIDTH = $clog2(DRAIN_TIMEOUT)`.

Ports:
- `clk`  in  1  clock. One clock domain; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  reconfiguration request.
- `cfg_offset`  in  ALGN_OFFSET_WIDTH  requested offset.
- `cfg_size`  in  ALGN_SIZE_WIDTH  requested size.
- `cfg_ready`  out  1  request accepted when `cfg_valid & cfg_ready`.
- `cfg_done`  out  1  one-cycle pulse: new config applied.
- `cfg_err`  out  2  one-cycle code: 0 none, 1 ILLEGAL, 2 TIMEOUT.
- `ctrl_offset`  out  ALGN_OFFSET_WIDTH  to `cfs_ctrl`.
- `ctrl_size`  out  ALGN_SIZE_WIDTH  to `cfs_ctrl`.
- `up_pop_valid`  in  1  from RX FIFO.
- `up_pop_ready`  out  1  to RX FIFO.
- `dp_pop_valid`  out  1  to `cfs_ctrl`.
- `dp_pop_ready`  in  1  from `cfs_ctrl`.
- `dp_pop_size`  in  ALGN_SIZE_WIDTH  size field of the popped word.
- `dp_push_valid`  in  1  monitor of the `cfs_ctrl` push port.
- `dp_push_ready`  in  1  monitor of the `cfs_ctrl` push port.
- `dp_push_size`  in  ALGN_SIZE_WIDTH  size field of the pushed word.
- `inflight`  out  CNT_WIDTH  bytes popped but not yet pushed.
- `busy`  out  1  state != IDLE.

## Operation
- Pop gating is combinational:
  - `hold = (state == DRAIN)`.
  - `dp_pop_valid = up_pop_valid & ~hold`.
  - `up_pop_ready = dp_pop_ready & ~hold`.
- Handshakes:
  - `pop_hs = dp_pop_valid & dp_pop_ready`.
  - `push_hs = dp_push_valid & dp_push_ready`.
- In-flight counter, registered every cycle: `inflight += (pop_hs ? dp_pop_size : 0) - (push_hs ? dp_push_size : 0)`.
  - Computed at CNT_WIDTH+1 bits.
  - Underflow saturates at 0 and overflow saturates at max; both are protocol violations, covered by assertions.
- Legality, combinational on the cfg inputs; a request is legal only if all hold:
  - `cfg_size != 0`
  - `cfg_size <= DATA_BYTES`
  - `cfg_offset + cfg_size <= DATA_BYTES`
  - `(DATA_BYTES + cfg_offset) % cfg_size == 0`
- `cfg_ready = (state == IDLE)`.
- FSM:
  - IDLE, accept of an illegal request: `cfg_err <= 1`, stay IDLE, `ctrl_*` unchanged.
  - IDLE, accept of a legal request: latch the request into `pend_offset`/`pend_size`, clear the timeout counter, go to DRAIN.
  - DRAIN, `inflight == 0`: `ctrl_offset <= pend_offset`, `ctrl_size <= pend_size`, `cfg_done <= 1`, go to IDLE.
  - DRAIN, `inflight != 0` and timeout counter `== DRAIN_TIMEOUT-1`: `cfg_err <= 2`, go to IDLE, `ctrl_*` unchanged. Residual partial bytes stay in `cfs_ctrl`; software must flush upstream.
  - DRAIN, otherwise: increment the timeout counter.
- The zero test uses the registered `inflight`. A push handshake in the current DRAIN cycle is reflected next cycle.
- A pop in the accept cycle (hold still low) is counted, and is drained before the apply.

## Timing
- Reset values:
  - `ctrl_offset = 0`, `ctrl_size = 1`
  - `cfg_done = 0`, `cfg_err = 0`
  - `inflight = 0`, `busy = 0`, state IDLE
  - `cfg_ready = 1`
  - `dp_pop_valid`/`up_pop_ready` are the pass-through of their inputs.
- Minimum latency, accept at T with the datapath idle:
  - DRAIN at T+1, with `hold` and `busy` high.
  - New `ctrl_*`, `cfg_done` high and state IDLE all at T+2.
- Pop gating:
  - Pops are blocked for exactly the DRAIN cycles.
  - The first pop possible after an apply already sees the new `ctrl_*`.
- Error timing:
  - ILLEGAL: `cfg_err` high at T+1.
  - TIMEOUT: `cfg_err` high at T+1+DRAIN_TIMEOUT.
- `cfg_done` and `cfg_err` are never high together.
- Reset asserted mid-DRAIN: immediately return to reset values, drop `hold`, discard the pending request.

## Structure
- Shared package `cfs_algn_pkg`:
  - `cfs_algn_err_t` (NONE, ILLEGAL, TIMEOUT).
  - `cfs_algn_cfg_state_t` (IDLE, DRAIN).
  - Function `algn_cfg_legal(offset, size, data_bytes)`, reused by the register block and the scoreboard.
- One sub-module: `cfs_algn_inflight_cnt`, the saturating byte counter with pop/push size inputs. The FSM, legality check and gating live in the top module.

## Test plan
- Reset with `ALGN_DATA_WIDTH=32` → `ctrl_offset=0`, `ctrl_size=1`, `cfg_ready=1`, `inflight=0`, `busy=0`.
- Datapath idle, request offset=2 size=2 accepted at T → `hold` high only at T+1; `ctrl_offset=2`, `ctrl_size=2`, `cfg_done=1` at T+2.
- Request offset=1 size=2, then offset=0 size=3 → `cfg_err=1` each at T+1, `ctrl_*` stay 0/1, no `busy`.
- Pop of size 4 with ctrl_size=1 and `dp_push_ready=0`, then request 0/4 → `up_pop_ready=0` throughout DRAIN.
  - Release `dp_push_ready`; after 4 push handshakes `inflight` reaches 0 and `ctrl_size=4` the next cycle.
- ctrl_size=4, single pop of size 1 (stuck partial), request 0/2 → `cfg_err=2` exactly 257 cycles after accept, `ctrl_size` still 4, `hold` released.
- Reset asserted 3 cycles into DRAIN → `busy=0`, `ctrl_*` reset values, `up_pop_ready` follows `dp_pop_ready`, no `cfg_done`.
